// File: rtl/alu_reg_datapath.sv
// alu_reg_datapath: small register file plus ALU, sequenced by a four-state
// controller (IDLE -> READ -> EXEC -> WRITE). One command is in flight at a
// time; results, flags and the register write all land when leaving WRITE.
module alu_reg_datapath #(
   parameter  int WIDTH = 8,
   parameter  int REGS  = 4,
   localparam int AW    = (REGS > 1) ? $clog2(REGS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [AW-1:0]    rs1,
   input  logic [AW-1:0]    rs2,
   input  logic [AW-1:0]    rd,
   input  logic [WIDTH-1:0] imm,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic [WIDTH-1:0] result,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NOT  = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_LOAD = 3'b111;

   // Index space fully populated: every index is a real register.
   localparam bit FULL_MAP = (REGS == (1 << AW));

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q;
   logic [AW-1:0]    rs1_q, rs2_q, rd_q;
   logic [WIDTH-1:0] imm_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH:0]   alu_q, alu_d;
   logic [WIDTH-1:0] regs_q [REGS];
   logic [WIDTH-1:0] result_q;
   logic             carry_q, zero_q, done_q;

   function automatic logic in_range(input logic [AW-1:0] idx);
      return FULL_MAP || (32'(idx) < REGS);
   endfunction

   function automatic logic [WIDTH-1:0] reg_read(input logic [AW-1:0] idx);
      return in_range(idx) ? regs_q[idx] : '0;
   endfunction

   // Controller state register.
   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: fixed one-cycle-per-state walk, start only seen in IDLE.
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WRITE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Command latch: fields are captured only when a command is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q  <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         rd_q  <= '0;
         imm_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         op_q  <= opcode;
         rs1_q <= rs1;
         rs2_q <= rs2;
         rd_q  <= rd;
         imm_q <= imm;
      end
   end

   // Operand fetch in READ; sees the register file before this command writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (state_q == S_READ) begin
         a_q <= reg_read(rs1_q);
         b_q <= reg_read(rs2_q);
      end
   end

   // ALU: WIDTH+1-bit result whose top bit is the carry/borrow candidate.
   always_comb begin
      alu_d = '0;
      unique case (op_q)
         OP_ADD:  alu_d = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB:  alu_d = {1'b0, a_q} - {1'b0, b_q};
         OP_AND:  alu_d = {1'b0, a_q & b_q};
         OP_OR:   alu_d = {1'b0, a_q | b_q};
         OP_XOR:  alu_d = {1'b0, a_q ^ b_q};
         OP_NOT:  alu_d = {1'b0, ~a_q};
         OP_SHL:  alu_d = {a_q, 1'b0};
         OP_LOAD: alu_d = {1'b0, imm_q};
         default: alu_d = '0;
      endcase
   end

   // EXEC stage register for the ALU output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   alu_q <= '0;
      else if (state_q == S_EXEC)  alu_q <= alu_d;
   end

   // Register file write when leaving WRITE; out-of-range rd writes nothing.
   // NOTE: this storage is reset explicitly because all registers must read 0 after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
      end else if (state_q == S_WRITE && in_range(rd_q)) begin
         regs_q[rd_q] <= alu_q[WIDTH-1:0];
      end
   end

   // Writeback of result/flags and the single-cycle done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == S_WRITE);
         if (state_q == S_WRITE) begin
            result_q <= alu_q[WIDTH-1:0];
            zero_q   <= (alu_q[WIDTH-1:0] == '0);
            if (op_q != OP_LOAD) carry_q <= alu_q[WIDTH];
         end
      end
   end

   // Combinational debug read port.
   always_comb begin
      dbg_data = reg_read(dbg_addr);
   end

   assign result     = result_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;
   assign done       = done_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/alu_reg_datapath.md
ALU_REG_DATAPATH -- requirements
Module: alu_reg_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, register and result width in bits (min 4).
REQ-002 SHALL have parameter REGS, default 4: register file depth (min 2); AW = clog2(REGS) is derived, not user-set.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  command request; sampled only when busy=0.
REQ-006 SHALL have port opcode  input  3  operation select, latched with start.
REQ-007 SHALL have ports rs1, rs2, rd  input  AW each  source A, source B and destination register indices.
REQ-008 SHALL have port imm  input  WIDTH  immediate value for LOAD.
REQ-009 SHALL have port dbg_addr  input  AW  combinational register read address.
REQ-010 SHALL have port dbg_data  output  WIDTH  register[dbg_addr]; 0 if dbg_addr >= REGS.
REQ-011 SHALL have port result  output  WIDTH  last written-back value (registered).
REQ-012 SHALL have ports carry_flag, zero_flag  output  1 each  registered status of last operation.
REQ-013 SHALL have port busy  output  1  high while a command is in flight.
REQ-014 SHALL have port done  output  1  one-cycle pulse after writeback.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> EXEC -> WRITE -> IDLE, one state per cycle, no stalls.
REQ-016 In IDLE with start=1 at edge E: latch opcode/rs1/rs2/rd/imm, go to READ; busy=1 after E, E+1 and E+2.
REQ-017 READ SHALL capture operands a=reg[rs1], b=reg[rs2]; rs1/rs2 may equal rd, giving pre-write values.
REQ-018 EXEC SHALL compute a WIDTH+1-bit result per opcode: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 SHL a by 1; 111 LOAD imm.
REQ-019 Carry rules: ADD = bit WIDTH of sum; SUB = borrow (1 iff a<b); SHL = a[WIDTH-1]; AND/OR/XOR/NOT = 0; LOAD leaves carry_flag unchanged.
REQ-020 zero_flag SHALL be 1 iff the WIDTH-bit result is 0, for every opcode including LOAD.
REQ-021 At edge E+3 (leaving WRITE): reg[rd], result, carry_flag and zero_flag update; FSM returns to IDLE; busy=0 and done=1 for exactly that following cycle.
REQ-022 start while busy=1 SHALL be ignored, with no latching and no queueing; next acceptance earliest at edge E+4 (one command per 4 cycles with start held high).
REQ-023 rd >= REGS (non-power-of-2 REGS) SHALL suppress the register write; result and flags still update, done still pulses.
REQ-024 dbg_data SHALL be purely combinational; a read of rd in the done cycle SHALL return the new value.
REQ-025 Arithmetic wraps modulo 2^WIDTH; no saturation.

Reset
REQ-026 reset=1 SHALL immediately force FSM=IDLE, all registers=0, result=0, carry_flag=0, zero_flag=0, busy=0, done=0, independent of clk.
REQ-027 Reset mid-operation SHALL abort the command with no register write and no done pulse; the first edge after deassertion accepts start normally.

Verification
REQ-028 WIDTH=8, REGS=4: LOAD r1=200; LOAD r2=100; ADD r3=r1+r2 -> result=44, carry=1, zero=0, dbg r3=44, done 4 cycles after start.
REQ-029 SUB r0=r2-r1 (100-200) -> result=156, carry=1; then SUB r0=r1-r1 -> result=0, zero=1, carry=0.
REQ-030 Pulse start with a second opcode during busy -> ignored; exactly one done; only the first rd changes.
REQ-031 Assert reset during EXEC of ADD r3 -> busy=0 and all dbg reads 0 without a clk edge; no done pulse.
REQ-032 WIDTH=16, REGS=8: LOAD r7=0xFFFF; SHL r7=r7 -> result=0xFFFE, carry=1; LOAD r6=0 -> zero=1, carry stays 1.
REQ-033 start held high for 3 commands -> done pulses 4 cycles apart; ADD r2=r2+r2 uses the pre-write r2.
